seg7_to_hex_decoder: RTL and testbench



---
 rtl/seg7_to_hex_decoder.sv | 131 +++++++++++++
 tb/tb_seg7_to_hex_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_to_hex_decoder.sv
// seg7_to_hex_decoder
// Samples a 7-segment bus (bit0 = a .. bit6 = g), waits until the pattern has
// been seen STABLE_CYCLES times in a row, then reports the decoded hex digit
// once over a valid/ready handshake. Patterns that are not one of the sixteen
// canonical glyphs are reported with seg_err = 1 and hex_out = 0. The blank
// (all segments off) pattern is the idle state and is never reported.
//
// Optional feature: define SEG7DEC_ERRCNT_EN to add err_cnt, a saturating
// count of accepted non-canonical patterns (dropped ones included).
module seg7_to_hex_decoder #(
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] hex_out,
  output logic       seg_err,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef SEG7DEC_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic [7:0] drop_cnt
);

  localparam logic [6:0] SEG_BLANK  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic [7:0] stab_cnt;
  logic       done;

  logic [6:0] pat_hi;
  logic [3:0] dec_hex;
  logic       dec_err;
  logic       pat_blank;
  logic       accept;
  logic       emit;
  logic       can_load;

  // Normalise the held sample to active-high so one glyph table serves both polarities.
  assign pat_hi    = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign pat_blank = (seg_q == SEG_BLANK);
  assign accept    = (stab_cnt == STABLE_MAX) && !done;
  assign emit      = accept && !pat_blank;
  assign can_load  = !out_valid || out_ready;

  // Glyph lookup on the held sample; anything off-table is an error with digit 0.
  always_comb begin
    dec_hex = 4'h0;
    dec_err = 1'b0;
    case (pat_hi)
      7'h3F: dec_hex = 4'h0;
      7'h06: dec_hex = 4'h1;
      7'h5B: dec_hex = 4'h2;
      7'h4F: dec_hex = 4'h3;
      7'h66: dec_hex = 4'h4;
      7'h6D: dec_hex = 4'h5;
      7'h7D: dec_hex = 4'h6;
      7'h07: dec_hex = 4'h7;
      7'h7F: dec_hex = 4'h8;
      7'h6F: dec_hex = 4'h9;
      7'h77: dec_hex = 4'hA;
      7'h7C: dec_hex = 4'hB;
      7'h39: dec_hex = 4'hC;
      7'h5E: dec_hex = 4'hD;
      7'h79: dec_hex = 4'hE;
      7'h71: dec_hex = 4'hF;
      default: begin
        dec_hex = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  // Sampler and stability tracker; done marks the held pattern as already handled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q    <= SEG_BLANK;
      stab_cnt <= 8'd0;
      done     <= 1'b1;
    end else begin
      seg_q <= seg_in;
      if (seg_in != seg_q) begin
        stab_cnt <= 8'd1;
        done     <= 1'b0;
      end else begin
        stab_cnt <= (stab_cnt >= STABLE_MAX) ? STABLE_MAX : stab_cnt + 8'd1;
        if (accept) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Result register with handshake; a result arriving while one is stuck is counted as dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_out   <= 4'h0;
      seg_err   <= 1'b0;
      out_valid <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      if (emit && can_load) begin
        hex_out   <= dec_hex;
        seg_err   <= dec_err;
        out_valid <= 1'b1;
      end else begin
        if (emit && drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SEG7DEC_ERRCNT_EN
  // Saturating tally of accepted off-table patterns, whether delivered or dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (emit && dec_err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_to_hex_decoder.sv
// Directed bench for seg7_to_hex_decoder with the default parameters
// (active-low segments, four stable samples).
module tb_seg7_to_hex_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] hex_out;
  logic       seg_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] drop_cnt;
`ifdef SEG7DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  seg7_to_hex_decoder #(.ACTIVE_LOW(1), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .hex_out   (hex_out),
    .seg_err   (seg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SEG7DEC_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations gathered while holding patterns
  int          hs_cnt;
  int          first_valid;
  int          valid_cycles;
  logic [3:0]  last_hex;
  logic        last_err;
  logic [15:0] seen;

  logic [6:0] glyph_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic clear_obs();
    hs_cnt       = 0;
    first_valid  = -1;
    valid_cycles = 0;
    last_hex     = 4'h0;
    last_err     = 1'b0;
    seen         = 16'h0;
  endtask

  // Drive a pattern for a number of edges, sampling 1 ns after each edge.
  task automatic run(input logic [6:0] pat, input int cycles);
    seg_in = pat;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = i;
        last_hex = hex_out;
        last_err = seg_err;
        if (out_ready) begin
          hs_cnt++;
          seen[hex_out] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    seg_in    = 7'h7F;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || hex_out !== 4'h0 || seg_err !== 1'b0 || drop_cnt !== 8'h00)
      $display("FAIL reset_values: valid=%b hex=%h err=%b drop=%0d, want 0/0/0/0",
               out_valid, hex_out, seg_err, drop_cnt);
    else n_pass++;
    rst_n = 1'b1;
    clear_obs();
    run(7'h7F, 20);
    n_checks++;
    if (valid_cycles !== 0) $display("FAIL blank_idle: valid cycles=%0d, want 0", valid_cycles);
    else n_pass++;
    n_checks++;
    if (hex_out !== 4'h0 || seg_err !== 1'b0 || drop_cnt !== 8'h00)
      $display("FAIL blank_outputs: hex=%h err=%b drop=%0d, want 0/0/0", hex_out, seg_err, drop_cnt);
    else n_pass++;
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      clear_obs();
      run(glyph_lo[d], 20);
      n_checks++;
      if (hs_cnt !== 1 || valid_cycles !== 1)
        $display("FAIL sweep_once[%0d]: handshakes=%0d valid cycles=%0d, want 1/1", d, hs_cnt, valid_cycles);
      else n_pass++;
      n_checks++;
      if (first_valid !== 5)
        $display("FAIL sweep_latency[%0d]: valid at edge %0d, want 5", d, first_valid);
      else n_pass++;
      n_checks++;
      if (last_hex !== 4'(d) || last_err !== 1'b0)
        $display("FAIL sweep_value[%0d]: hex=%h err=%b, want %h/0", d, last_hex, last_err, 4'(d));
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    out_ready = 1'b1;
    clear_obs();
    run(7'h24, 3);
    run(7'h79, 10);
    n_checks++;
    if (hs_cnt !== 1 || last_hex !== 4'h1 || last_err !== 1'b0)
      $display("FAIL glitch_emit: handshakes=%0d hex=%h err=%b, want 1/1/0", hs_cnt, last_hex, last_err);
    else n_pass++;
    n_checks++;
    if (seen[2] !== 1'b0) $display("FAIL glitch_suppress: digit 2 seen=%b, want 0", seen[2]);
    else n_pass++;
    n_checks++;
    if (first_valid !== 5) $display("FAIL glitch_latency: valid at edge %0d, want 5", first_valid);
    else n_pass++;
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    clear_obs();
    run(7'h55, 10);
    n_checks++;
    if (hs_cnt !== 1 || last_err !== 1'b1 || last_hex !== 4'h0)
      $display("FAIL invalid_pattern: handshakes=%0d err=%b hex=%h, want 1/1/0", hs_cnt, last_err, last_hex);
    else n_pass++;
`ifdef SEG7DEC_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'd1) $display("FAIL err_cnt_one: err_cnt=%0d, want 1", err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    clear_obs();
    run(7'h40, 10);
    run(7'h30, 10);
    run(7'h19, 10);
    n_checks++;
    if (out_valid !== 1'b1 || hex_out !== 4'h0 || seg_err !== 1'b0)
      $display("FAIL bp_hold: valid=%b hex=%h err=%b, want 1/0/0", out_valid, hex_out, seg_err);
    else n_pass++;
    n_checks++;
    if (valid_cycles !== 26) $display("FAIL bp_steady: valid cycles=%0d, want 26", valid_cycles);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 8'd2) $display("FAIL bp_drop: drop_cnt=%0d, want 2", drop_cnt);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_release: valid=%b, want 0", out_valid);
    else n_pass++;
    clear_obs();
    run(7'h19, 4);
    n_checks++;
    if (valid_cycles !== 0) $display("FAIL bp_no_repeat: valid cycles=%0d, want 0", valid_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_midway();
    out_ready = 1'b0;
    clear_obs();
    run(7'h79, 10);
    n_checks++;
    if (out_valid !== 1'b1 || hex_out !== 4'h1)
      $display("FAIL rst_pending: valid=%b hex=%h, want 1/1", out_valid, hex_out);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || hex_out !== 4'h0)
      $display("FAIL rst_clear: valid=%b drop=%0d hex=%h, want 0/0/0", out_valid, drop_cnt, hex_out);
    else n_pass++;
`ifdef SEG7DEC_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: err_cnt=%0d, want 0", err_cnt);
    else n_pass++;
`endif
    clear_obs();
    run(7'h79, 20);
    n_checks++;
    if (first_valid !== 5 || hs_cnt !== 1 || last_hex !== 4'h1)
      $display("FAIL rst_reemit: edge=%0d handshakes=%0d hex=%h, want 5/1/1", first_valid, hs_cnt, last_hex);
    else n_pass++;
  endtask

  task automatic test_drop_saturation();
    out_ready = 1'b0;
    for (int k = 0; k < 250; k++) run((k % 2 == 0) ? 7'h40 : 7'h79, 5);
    n_checks++;
    if (drop_cnt !== 8'd249) $display("FAIL drop_count: drop_cnt=%0d, want 249", drop_cnt);
    else n_pass++;
    for (int k = 250; k < 300; k++) run((k % 2 == 0) ? 7'h40 : 7'h79, 5);
    n_checks++;
    if (drop_cnt !== 8'd255) $display("FAIL drop_saturate: drop_cnt=%0d, want 255", drop_cnt);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || hex_out !== 4'h0)
      $display("FAIL drop_first_kept: valid=%b hex=%h, want 1/0", out_valid, hex_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_glitch();
    test_invalid();
    test_backpressure();
    test_reset_midway();
    test_drop_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
